// File: rtl/sysid_check_master.sv
// Avalon-MM read master that reads and checks the sysid ID and timestamp words.
// Define SYSID_CHECK_PERIODIC_EN to add an automatic re-check every PERIOD_CYCLES.
module sysid_check_master #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1652369592,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned PERIOD_CYCLES  = 1000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        CMP   = 2'd3
    } state_t;

    localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYCLES);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] wait_q;
    logic        id_eq_q;
    logic        reading;
    logic        xfer;
    logic        expire;
    logic        start_ok;
    logic        go;

    assign reading  = (state_q == RD_ID) || (state_q == RD_TS);
    assign xfer     = reading && !avm_waitrequest;
    // wait_q counts earlier stalls, so this cycle is stall number wait_q+1
    assign expire   = reading && avm_waitrequest &&
                      (({1'b0, wait_q} + 17'd1) >= TO_LIM);
    assign start_ok = start && ((state_q == IDLE) || (state_q == CMP));

`ifdef SYSID_CHECK_PERIODIC_EN
    logic [31:0] period_q;
    logic        tick;

    assign tick = (state_q == IDLE) &&
                  (period_q == 32'(PERIOD_CYCLES - 1));
    assign go   = start_ok || tick;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            period_q <= '0;
        end else if (go) begin
            period_q <= '0;
        end else if (state_q == IDLE) begin
            period_q <= period_q + 32'd1;
        end
    end
`else
    assign go = start_ok;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (go) state_d = RD_ID;
            RD_ID: begin
                if (xfer)        state_d = RD_TS;
                else if (expire) state_d = CMP;
            end
            RD_TS:   if (xfer || expire) state_d = CMP;
            CMP:     state_d = go ? RD_ID : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign avm_read    = reset_n && reading;
    assign avm_address = (state_q == RD_TS) ? BASE_ADDR + 32'd4 : BASE_ADDR;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == CMP);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wait_q   <= '0;
            id_eq_q  <= 1'b0;
            id_match <= 1'b0;
            ts_match <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            state_q <= state_d;
            if (go) begin
                wait_q   <= '0;
                id_eq_q  <= 1'b0;
                id_match <= 1'b0;
                ts_match <= 1'b0;
                timeout  <= 1'b0;
                id_value <= '0;
                ts_value <= '0;
            end else if (reading) begin
                if (xfer || expire) begin
                    wait_q <= '0;
                end else if (wait_q != 16'hFFFF) begin
                    wait_q <= wait_q + 16'd1;
                end
                if (expire) begin
                    timeout <= 1'b1;
                end
                if (xfer && (state_q == RD_ID)) begin
                    id_value <= avm_readdata;
                    id_eq_q  <= (avm_readdata == EXPECTED_ID);
                end
                // flags land as CMP is entered so they are valid with done
                if (xfer && (state_q == RD_TS)) begin
                    ts_value <= avm_readdata;
                    id_match <= id_eq_q;
                    ts_match <= (avm_readdata == EXPECTED_TS);
                end
            end
        end
    end

endmodule

// File: tb/tb_sysid_check_master.sv
// Randomized bench for sysid_check_master with a behavioural slave
// and an arithmetic latency/outcome model.
module tb_sysid_check_master;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] EID  = 32'hCAFE_0001;
    localparam logic [31:0] ETS  = 32'd1652369592;
    localparam int          TO   = 6;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    logic        busy;
    logic        done;
    logic        id_match;
    logic        ts_match;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    int checks = 0;
    int errors = 0;

    sysid_check_master #(
        .BASE_ADDR(BASE),
        .EXPECTED_ID(EID),
        .EXPECTED_TS(ETS),
        .TIMEOUT_CYCLES(TO),
        .PERIOD_CYCLES(20)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .avm_address(avm_address),
        .avm_read(avm_read),
        .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .busy(busy),
        .done(done),
        .id_match(id_match),
        .ts_match(ts_match),
        .timeout(timeout),
        .id_value(id_value),
        .ts_value(ts_value)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // s0/s1: stall cycles the slave inserts before answering each word
    task automatic run_check(input int s0, input int s1,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input bit pre, input bit chain, input bit dbl);
        int          phase;
        int          p;
        int          rem[2];
        logic [31:0] dat[2];
        int          exp_dc;
        int          exp_reads;
        bit          exp_to;
        bit          exp_idm;
        bit          exp_tsm;
        logic [31:0] exp_idv;
        logic [31:0] exp_tsv;
        int          reads;
        int          busy_n;
        int          ndone;
        int          dc;
        int          tail;
        bit          fin;
        phase = 0; reads = 0; busy_n = 0; ndone = 0;
        dc = -1; tail = 0; fin = 0;
        rem[0] = s0; rem[1] = s1;
        dat[0] = d0; dat[1] = d1;
        exp_idm = 0; exp_tsm = 0;
        if (s0 >= TO) begin
            exp_to = 1; exp_dc = TO + 1; exp_reads = TO;
            exp_idv = '0; exp_tsv = '0;
        end else if (s1 >= TO) begin
            exp_to = 1; exp_dc = s0 + TO + 2; exp_reads = s0 + 1 + TO;
            exp_idv = d0; exp_tsv = '0;
        end else begin
            exp_to = 0; exp_dc = s0 + s1 + 3; exp_reads = s0 + s1 + 2;
            exp_idv = d0; exp_tsv = d1;
            exp_idm = (d0 == EID); exp_tsm = (d1 == ETS);
        end
        if (!pre) begin
            @(negedge clock);
            start = 1'b1;
        end
        for (int c = 1; c <= 80 && !fin; c++) begin
            @(negedge clock);
            start = dbl && (c == 1);
            if (busy) busy_n++;
            if (avm_read) begin
                reads++;
                p = (phase > 1) ? 1 : phase;
                check("addr", avm_address, BASE + 32'(4 * p));
                if (rem[p] > 0) begin
                    rem[p]--;
                    avm_waitrequest = 1'b1;
                    avm_readdata = $urandom;
                end else begin
                    avm_waitrequest = 1'b0;
                    avm_readdata = dat[p];
                    phase++;
                end
            end else begin
                avm_waitrequest = 1'($urandom % 2);
                avm_readdata = $urandom;
            end
            if (done) begin
                ndone++;
                if (dc < 0) begin
                    dc = c;
                    check("timeout", {31'd0, timeout}, {31'd0, exp_to});
                    check("id_match", {31'd0, id_match}, {31'd0, exp_idm});
                    check("ts_match", {31'd0, ts_match}, {31'd0, exp_tsm});
                    check("id_value", id_value, exp_idv);
                    check("ts_value", ts_value, exp_tsv);
                end
                if (chain) begin
                    start = 1'b1;
                    fin = 1;
                end
            end
            if (dc >= 0 && !fin) begin
                tail++;
                if (tail > 3) fin = 1;
            end
        end
        check("done_cycle", dc, exp_dc);
        check("done_count", ndone, 1);
        check("busy_cycles", busy_n, exp_dc);
        check("read_cycles", reads, exp_reads);
    endtask

    task automatic reset_mid_read();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("rst_read_id", {31'd0, avm_read}, 32'd1);
        avm_waitrequest = 1'b0;
        avm_readdata = EID;
        @(negedge clock);
        check("rst_addr_ts", avm_address, BASE + 32'd4);
        avm_waitrequest = 1'b1;
        reset_n = 1'b0;
        #1;
        check("rst_read", {31'd0, avm_read}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_id_value", id_value, 32'd0);
        check("rst_addr", avm_address, BASE);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        int          s0;
        int          s1;
        logic [31:0] d0;
        logic [31:0] d1;
        repeat (3) @(negedge clock);
        check("reset_read", {31'd0, avm_read}, 32'd0);
        check("reset_addr", avm_address, BASE);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_flags", {29'd0, id_match, ts_match, timeout}, 32'd0);
        check("reset_id_value", id_value, 32'd0);
        check("reset_ts_value", ts_value, 32'd0);
        reset_n = 1'b1;

        run_check(0, 0, EID, ETS, 0, 0, 0);
        run_check(0, 0, EID ^ 32'd1, ETS, 0, 0, 0);
        run_check(0, 5, EID, ETS, 0, 0, 0);
        run_check(TO - 1, TO - 1, EID, ETS ^ 32'h80, 0, 0, 1);
        run_check(TO + 3, 0, EID, ETS, 0, 0, 0);
        run_check(1, TO, EID, ETS, 0, 0, 0);
        run_check(0, 0, EID, ETS, 0, 1, 0);
        run_check(2, 1, 32'h1234_5678, ETS, 1, 0, 0);
        reset_mid_read();
        run_check(0, 0, EID, ETS, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom % 4 == 0) s0 = $urandom_range(0, TO + 2);
            else s0 = $urandom_range(0, 2);
            if ($urandom % 4 == 0) s1 = $urandom_range(0, TO + 2);
            else s1 = $urandom_range(0, 2);
            d0 = ($urandom % 2 == 0) ? EID : $urandom;
            d1 = ($urandom % 2 == 0) ? ETS : $urandom;
            run_check(s0, s1, d0, d1, 0, 0, ($urandom % 4) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
